// File: rtl/run_ctrl_fsm_if.sv
// Processor execution handshake between the front-panel controller (master)
// and the microsequencer (slave).
interface run_ctrl_fsm_if;
  logic cpu_en;
  logic cpu_ack;

  modport master (output cpu_en, input cpu_ack);
  modport slave  (input cpu_en, output cpu_ack);
endinterface

// File: rtl/run_ctrl_fsm.sv
// MIC-1 front-panel execution controller: button debounce, run/step/burst sequencing,
// microcycle counter. Breakpoint/HALT support is built when RUN_CTRL_BREAKPOINT_EN is defined.
module run_ctrl_fsm #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 16,
  parameter int BURST_N   = 4,
  parameter int LED_W     = 4,
  parameter int N_BTN     = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_BTN-1:0]   button,
  run_ctrl_fsm_if.master     cpu_bus,
  input  logic               bp_en,
  input  logic [CNT_W-1:0]   bp_value,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [2:0]         state,
  output logic               led_run_status,
  output logic               led_idle,
  output logic               led_halt,
  output logic [LED_W-1:0]   led_run_step
);

  localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_BURST = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  logic [N_BTN-1:0] w_press;

  // Per-button synchroniser and debouncer; the press pulse coincides with
  // the clk edge on which the debounced level rises.
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_diff;

    assign w_diff      = r_sync2 ^ r_level;
    assign w_press[gi] = w_diff & ~r_level & (r_db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
      if (resetn) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_level  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_sync1 <= button[gi];
        r_sync2 <= r_sync1;
        if (!w_diff) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
          r_db_cnt <= '0;
          r_level  <= ~r_level;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end
  end

  // Priority: stop > run > step > burst > clear.
  logic w_ev_stop, w_ev_run, w_ev_step, w_ev_burst, w_ev_clear;
  assign w_ev_stop  = w_press[3];
  assign w_ev_run   = w_press[0] & ~w_press[3];
  assign w_ev_step  = w_press[2] & ~w_press[3] & ~w_press[0];
  assign w_ev_burst = w_press[1] & ~w_press[3] & ~w_press[0] & ~w_press[2];
  assign w_ev_clear = w_press[4] & ~w_press[3] & ~w_press[0] & ~w_press[2] & ~w_press[1];

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_rem, w_rem_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cpu_en;
  logic             w_exec;
  logic             w_bp_hit;

  assign w_cpu_en  = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_BURST);
  assign w_exec    = w_cpu_en & cpu_bus.cpu_ack;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic r_bp_armed;

  assign w_bp_hit = bp_en & r_bp_armed & w_exec & (w_cnt_inc == bp_value);

  // Disarm on HALT entry so resuming at bp_value cannot re-trigger at once.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_bp_armed <= 1'b1;
    end else if ((w_state_next == S_HALT) && (r_state != S_HALT)) begin
      r_bp_armed <= 1'b0;
    end else if (w_exec) begin
      r_bp_armed <= 1'b1;
    end
  end
`else
  logic w_unused_bp;

  assign w_bp_hit    = 1'b0;
  assign w_unused_bp = ^{bp_en, bp_value};
`endif

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rem   <= w_rem_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_exec ? w_cnt_inc : r_cnt;
    w_rem_next   = r_rem;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (w_ev_stop) begin
          w_state_next = S_IDLE;
        end else if (w_ev_run) begin
          w_state_next = S_RUN;
        end else if (w_ev_step) begin
          w_state_next = S_STEP;
        end else if (w_ev_burst) begin
          w_state_next = S_BURST;
          w_rem_next   = CNT_W'(BURST_N);
        end else if (w_ev_clear) begin
          w_cnt_next   = '0;
        end
      end
      S_RUN: begin
        if (w_ev_stop) begin
          w_state_next = S_IDLE;
        end else if (w_bp_hit) begin
          w_state_next = S_HALT;
        end
      end
      S_STEP: begin
        if (w_ev_stop || w_exec) begin
          w_state_next = S_IDLE;
        end
      end
      S_BURST: begin
        if (w_ev_stop) begin
          w_state_next = S_IDLE;
          w_rem_next   = '0;
        end else if (w_exec) begin
          w_rem_next = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state_next = S_IDLE;
          end else if (w_bp_hit) begin
            w_state_next = S_HALT;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign cpu_bus.cpu_en = w_cpu_en;
  assign cycle_cnt      = r_cnt;
  assign state          = r_state;
  assign led_run_status = w_cpu_en;
  assign led_idle       = (r_state == S_IDLE);
`ifdef RUN_CTRL_BREAKPOINT_EN
  assign led_halt       = (r_state == S_HALT);
`else
  assign led_halt       = 1'b0;
`endif
  assign led_run_step   = r_cnt[LED_W-1:0];

endmodule

// File: tb/tb_run_ctrl_fsm.sv
// Scoreboard bench for run_ctrl_fsm: expectations queued at stimulus time,
// popped and compared once the DUT has had the clocks to respond.
module tb_run_ctrl_fsm;
  localparam int DB    = 4;
  localparam int CW    = 8;
  localparam int LW    = 4;

  logic          clk;
  logic          resetn;
  logic [4:0]    button;
  logic          bp_en;
  logic [CW-1:0] bp_value;
  logic [CW-1:0] cycle_cnt;
  logic [2:0]    state;
  logic          led_run_status;
  logic          led_idle;
  logic          led_halt;
  logic [LW-1:0] led_run_step;

  run_ctrl_fsm_if u_bus ();

  run_ctrl_fsm #(
    .DB_CYCLES (DB),
    .CNT_W     (CW),
    .BURST_N   (4),
    .LED_W     (LW),
    .N_BTN     (5)
  ) u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .button         (button),
    .cpu_bus        (u_bus),
    .bp_en          (bp_en),
    .bp_value       (bp_value),
    .cycle_cnt      (cycle_cnt),
    .state          (state),
    .led_run_status (led_run_status),
    .led_idle       (led_idle),
    .led_halt       (led_halt),
    .led_run_step   (led_run_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a button until its press event has been taken, then release it.
  task automatic press(input int idx);
    button[idx] = 1'b1;
    tick(DB + 2);
    button[idx] = 1'b0;
  endtask

  task automatic settle();
    tick(DB + 2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b1;
    button        = '0;
    bp_en         = 1'b0;
    bp_value      = '0;
    u_bus.cpu_ack = 1'b0;
    tick(3);
    resetn = 1'b0;

    // Reset state
    sb_push("rst_state", 0);  sb_push("rst_cnt", 0);   sb_push("rst_idle", 1);
    sb_push("rst_runled", 0); sb_push("rst_halt", 0);  sb_push("rst_cpu_en", 0);
    sb_push("rst_ledstep", 0);
    sb_pop(32'(state)); sb_pop(32'(cycle_cnt)); sb_pop(32'(led_idle));
    sb_pop(32'(led_run_status)); sb_pop(32'(led_halt)); sb_pop(32'(u_bus.cpu_en));
    sb_pop(32'(led_run_step));

    // 1: bounce is rejected, clean press lands exactly DB+2 clks after the edge
    sb_push("t1_bounce_state", 0);
    button[0] = 1'b1; tick(3); button[0] = 1'b0; tick(10);
    sb_pop(32'(state));
    sb_push("t1_before_latency", 0);
    sb_push("t1_run_at_latency", 1);
    button[0] = 1'b1; tick(DB + 1);
    sb_pop(32'(state));
    tick(1);
    sb_pop(32'(state));
    tick(4); button[0] = 1'b0; settle();
    sb_push("t1_still_run", 1); sb_push("t1_cnt", 0);
    sb_pop(32'(state)); sb_pop(32'(cycle_cnt));

    // 2: 20 acked cycles in RUN, the stop cycle's ack included
    sb_push("t2_cnt", 20); sb_push("t2_state", 0); sb_push("t2_cpu_en", 0);
    sb_push("t2_ledstep", 4); sb_push("t2_runled", 0);
    u_bus.cpu_ack = 1'b1; tick(14);
    button[3] = 1'b1; tick(DB + 2);
    u_bus.cpu_ack = 1'b0; button[3] = 1'b0;
    sb_pop(32'(cycle_cnt)); sb_pop(32'(state)); sb_pop(32'(u_bus.cpu_en));
    sb_pop(32'(led_run_step)); sb_pop(32'(led_run_status));
    settle();

    // 3: clear, then a 4-cycle burst acked every other clk
    sb_push("t3_clear", 0);
    press(4);
    sb_pop(32'(cycle_cnt));
    settle();
    sb_push("t3_burst_state", 3); sb_push("t3_burst_cpu_en", 1);
    press(1);
    sb_pop(32'(state)); sb_pop(32'(u_bus.cpu_en));
    for (int i = 0; i < 4; i++) begin
      u_bus.cpu_ack = 1'b1; tick(1); u_bus.cpu_ack = 1'b0;
      if (i == 2) begin
        sb_push("t3_mid_cnt", 3); sb_push("t3_mid_state", 3);
        sb_pop(32'(cycle_cnt)); sb_pop(32'(state));
      end
      if (i == 3) begin
        sb_push("t3_end_state", 0); sb_push("t3_end_cnt", 4);
        sb_pop(32'(state)); sb_pop(32'(cycle_cnt));
      end
      tick(1);
    end
    sb_push("t3_ack_ignored", 4);
    u_bus.cpu_ack = 1'b1; tick(3); u_bus.cpu_ack = 1'b0;
    sb_pop(32'(cycle_cnt));

    // 4: breakpoint at 10, resume, wrap through 255
    bp_en = 1'b1; bp_value = 8'd10;
    press(4); settle();
    press(0);
    u_bus.cpu_ack = 1'b1; tick(10);
`ifdef RUN_CTRL_BREAKPOINT_EN
    sb_push("t4_halt_state", 4); sb_push("t4_halt_cnt", 10);
    sb_push("t4_led_halt", 1);   sb_push("t4_halt_cpu_en", 0);
    sb_pop(32'(state)); sb_pop(32'(cycle_cnt)); sb_pop(32'(led_halt)); sb_pop(32'(u_bus.cpu_en));
    sb_push("t4_resume_state", 1); sb_push("t4_resume_cnt", 10);
    press(0);
    sb_pop(32'(state)); sb_pop(32'(cycle_cnt));
`else
    sb_push("t4_nohalt_state", 1); sb_push("t4_nohalt_cnt", 10); sb_push("t4_led_halt", 0);
    sb_pop(32'(state)); sb_pop(32'(cycle_cnt)); sb_pop(32'(led_halt));
`endif
    sb_push("t4_cnt11", 11); sb_push("t4_state11", 1);
    tick(1);
    sb_pop(32'(cycle_cnt)); sb_pop(32'(state));
    sb_push("t4_cnt255", 255);
    tick(244);
    sb_pop(32'(cycle_cnt));
    sb_push("t4_wrap_cnt", 0); sb_push("t4_wrap_state", 1);
    tick(1);
    sb_pop(32'(cycle_cnt)); sb_pop(32'(state));
    u_bus.cpu_ack = 1'b0; bp_en = 1'b0;
    sb_push("t4_stop_state", 0);
    press(3);
    sb_pop(32'(state));
    settle();

    // 5: single step with late ack, then a step aborted by stop
    press(4); settle();
    sb_push("t5_step_state", 2); sb_push("t5_step_cpu_en", 1);
    press(2);
    sb_pop(32'(state)); sb_pop(32'(u_bus.cpu_en));
    sb_push("t5_wait_state", 2); sb_push("t5_wait_cpu_en", 1);
    tick(5);
    sb_pop(32'(state)); sb_pop(32'(u_bus.cpu_en));
    sb_push("t5_done_state", 0); sb_push("t5_done_cnt", 1); sb_push("t5_done_cpu_en", 0);
    u_bus.cpu_ack = 1'b1; tick(1); u_bus.cpu_ack = 1'b0;
    sb_pop(32'(state)); sb_pop(32'(cycle_cnt)); sb_pop(32'(u_bus.cpu_en));
    settle();
    sb_push("t5_abort_state", 0); sb_push("t5_abort_cnt", 1);
    press(2); tick(3); press(3);
    sb_pop(32'(state)); sb_pop(32'(cycle_cnt));
    settle();

    // 6: event priority, reset mid-burst, clear handling
    press(0); settle();
    sb_push("t6_stop_run_in_run", 0);
    button[0] = 1'b1; button[3] = 1'b1; tick(DB + 2); button = '0;
    sb_pop(32'(state));
    settle();
    sb_push("t6_stop_beats_run", 0);
    button[0] = 1'b1; button[3] = 1'b1; tick(DB + 2); button = '0;
    sb_pop(32'(state));
    settle();
    sb_push("t6_burst_state", 3); sb_push("t6_burst_cnt", 3);
    press(1);
    sb_pop(32'(state));
    u_bus.cpu_ack = 1'b1; tick(2);
    sb_pop(32'(cycle_cnt));
    sb_push("t6_rst_state", 0); sb_push("t6_rst_cnt", 0);
    sb_push("t6_rst_cpu_en", 0); sb_push("t6_rst_idle", 1);
    resetn = 1'b1; tick(1); resetn = 1'b0; u_bus.cpu_ack = 1'b0;
    sb_pop(32'(state)); sb_pop(32'(cycle_cnt)); sb_pop(32'(u_bus.cpu_en)); sb_pop(32'(led_idle));
    settle();
    press(0);
    u_bus.cpu_ack = 1'b1; tick(37); u_bus.cpu_ack = 1'b0;
    sb_push("t6_cnt37", 37);
    sb_pop(32'(cycle_cnt));
    settle();
    sb_push("t6_clear_in_run_cnt", 37); sb_push("t6_clear_in_run_state", 1);
    press(4);
    sb_pop(32'(cycle_cnt)); sb_pop(32'(state));
    settle();
    sb_push("t6_stop_idle", 0);
    press(3);
    sb_pop(32'(state));
    settle();
    sb_push("t6_clear_cnt", 0); sb_push("t6_clear_ledstep", 0);
    press(4);
    sb_pop(32'(cycle_cnt)); sb_pop(32'(led_run_step));

    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
